// File: rtl/serial_load_arbiter_pkg.sv
// serial_load_arbiter_pkg
//   Shared constants for the serial load arbiter: controller state encoding,
//   default word width and the width helper used for grant indices.
package serial_load_arbiter_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bits needed to index n requesters; never below 1 so ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_load_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: first set bit of req searching upward
//   from rr_ptr with wrap-around.
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  ID_W     highest-priority index this round
//   grant   out ID_W     chosen index (0 when nothing is requested)
//   any_req out 1        OR of req
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  assign any_req = |req;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_load_arbiter.sv
// serial_load_arbiter
//   Shares one serial input collector between NUM_REQ word producers. A
//   round-robin winner's word is latched, shifted out LSB-first while
//   ready_out is held low, then ready_out is raised and the collector's
//   data_ready is awaited (bounded by TIMEOUT) before acking the requester.
//   fast_clk      in  clock
//   reset         in  synchronous active-high reset
//   req           in  per-requester level request, held until ack
//   req_data      in  requester i word at [i*WORD_WIDTH +: WORD_WIDTH]
//   ack           out one-cycle one-hot completion pulse
//   grant_id      out current/last granted requester
//   busy          out high whenever the controller is not idle
//   serial_out    out collector serial_in
//   ready_out     out collector ready (low only while shifting)
//   data_ready_in in  collector data_ready
//   timeout_err   out sticky, set when data_ready never arrived
module serial_load_arbiter
  import serial_load_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 8,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          fast_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          serial_out,
  output logic                          ready_out,
  input  logic                          data_ready_in,
  output logic                          timeout_err
);

  localparam int BIT_W  = $clog2(WORD_WIDTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT);

  logic [1:0]                           state;
  logic [ID_W-1:0]                      rr_ptr;
  logic [ID_W-1:0]                      arb_grant;
  logic                                 any_req;
  logic [WORD_WIDTH-1:0]                shift_reg;
  logic [BIT_W-1:0]                     bit_cnt;
  logic [WAIT_W-1:0]                    wait_cnt;
  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]   words;
  logic [NUM_REQ-1:0]                   ack_onehot;
  logic [ID_W-1:0]                      next_ptr;

  assign words      = req_data;
  assign ack_onehot = NUM_REQ'(1) << grant_id;
  assign next_ptr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      shift_reg   <= '0;
      ack         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      serial_out  <= 1'b0;
      ready_out   <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            // Bit 0 goes out on the grant edge; shift_reg keeps the rest so
            // the SHIFT state always sends shift_reg[0].
            grant_id   <= arb_grant;
            shift_reg  <= words[arb_grant] >> 1;
            serial_out <= words[arb_grant][0];
            ready_out  <= 1'b0;
            bit_cnt    <= BIT_W'(1);
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == BIT_W'(WORD_WIDTH)) begin
            ready_out <= 1'b1;
            wait_cnt  <= '0;
            state     <= ST_WAIT;
          end else begin
            serial_out <= shift_reg[0];
            shift_reg  <= shift_reg >> 1;
            bit_cnt    <= bit_cnt + BIT_W'(1);
          end
        end
        ST_WAIT: begin
          if (data_ready_in) begin
            ack   <= ack_onehot;
            state <= ST_DONE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // Give up on the collector but still release the requester.
            timeout_err <= 1'b1;
            ack         <= ack_onehot;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DONE: begin
          ack    <= '0;
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_load_arbiter.md
Name: serial_load_arbiter

Overview:
- Shares one input_collector-style serial loader between NUM_REQ parallel-word requesters.
- Arbitrates round-robin and serializes the granted word LSB-first onto the collector's serial_in, holding ready low.
- Raises ready, waits for the collector's data_ready, then acks the requester.
- Sits between the on-chip word producers and the collector, in the fast_clk domain.

Parameters:
- WORD_WIDTH, 16: bits per word; must equal the collector OUTPUT_WIDTH; must be >= 2.
- NUM_REQ, 4: number of requesters; range 2..8.
- TIMEOUT, 8: max WAIT cycles for data_ready before abandoning the transfer; must be >= 2.

Ports:
- fast_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level; hold until ack.
- req_data  in  NUM_REQ*WORD_WIDTH  requester i word at bits [i*WORD_WIDTH +: WORD_WIDTH].
- ack  out  NUM_REQ  one-cycle, one-hot completion pulse.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- serial_out  out  1  drives collector serial_in.
- ready_out  out  1  drives collector ready.
- data_ready_in  in  1  from collector data_ready.
- timeout_err  out  1  sticky; set on WAIT timeout.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, grant_id=0, busy=0, serial_out=0, ready_out=1, timeout_err=0, state=IDLE, rr_ptr=0, bit_cnt=0, wait_cnt=0.
- ready_out idles high so the collector never shifts garbage.
- States: IDLE, SHIFT, WAIT, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch that requester's word into shift_reg; set grant_id.
  - Set serial_out <= word[0], ready_out <= 0, bit_cnt <= 1, busy <= 1; go to SHIFT.
  - If req is zero, stay in IDLE.
- SHIFT:
  - Each edge: if bit_cnt < WORD_WIDTH, set serial_out <= word[bit_cnt] and increment bit_cnt.
  - When bit_cnt == WORD_WIDTH, set ready_out <= 1, wait_cnt <= 0, and go to WAIT.
  - Net effect: ready_out is low for exactly WORD_WIDTH consecutive cycles, carrying bit k in the k-th cycle.
- WAIT:
  - If data_ready_in=1, set ack[grant_id] <= 1 and go to DONE.
  - Otherwise increment wait_cnt. When wait_cnt reaches TIMEOUT-1, set timeout_err <= 1, set ack[grant_id] <= 1, and go to DONE. The requester is released either way.
  - data_ready_in is cleared by the collector during SHIFT, so no stale value is possible on WAIT entry.
- DONE:
  - ack <= 0; rr_ptr <= (grant_id+1) mod NUM_REQ; busy <= 0; go to IDLE.
  - req is ignored in DONE. A requester still asserting req in the following IDLE is treated as a new request.
- Latency with an ideal collector: grant at edge 0, ack high in the cycle after edge WORD_WIDTH+2. The next grant is possible at edge WORD_WIDTH+4.
- Requester side:
  - Word data is captured at grant, so req_data may change afterwards.
  - Deasserting req mid-transfer has no effect; the transfer completes and ack still pulses.
- Simultaneous requests: exactly one grant per transfer, round-robin fair. Starvation bound: NUM_REQ-1 transfers.
- Reset mid-operation: abort immediately to reset values. No ack is issued for the aborted word. timeout_err is cleared.
- ready_out must never be low outside SHIFT.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, WAIT=2'd2, DONE=2'd3.
  - Default WORD_WIDTH.
  - Width helper for grant_id.
- Sub-module rr_arbiter (combinational):
  - Inputs: req, rr_ptr.
  - Outputs: grant index, any_req.
  - Separately testable.
- Controller FSM, shift register and counters live in serial_load_arbiter.

Test Plan:
- Single request: WORD_WIDTH=16, req=4'b0001, word 0xA5C3. Expect ready_out low for exactly 16 cycles with serial_out = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. Collector data=0xA5C3. ack=4'b0001 for 1 cycle, 19 edges after grant.
- All four requests held high continuously: grants in order 0,1,2,3,0. Each ack one-hot. No cycle with ready_out low outside SHIFT.
- rr_ptr=2 after a grant to 1, with req=4'b1011: next grant is 3, then 0, then 1.
- Collector held in its reset, data_ready stuck 0: timeout_err=1 after TIMEOUT WAIT cycles. ack still pulses. FSM returns to IDLE and serves the next request normally.
- reset asserted at bit 7 of a transfer: next cycle ready_out=1, busy=0, no ack. A re-issued request retransmits the full word and the collector shows the correct value.
- req_data changed and req dropped mid-SHIFT: transmitted word is the value latched at grant; ack still pulses once.
